// File: rtl/dd_spi_cfg_rx.sv
// SPI configuration receiver: deserialises address/payload frames into the view-window registers.
// Optional even-parity trailer bit enabled by defining DD_SPI_PARITY_EN.
module dd_spi_cfg_rx #(
    parameter int DATA_W = 16,
    parameter int ITER_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_en,
    input  logic              spi_data,
    output logic [DATA_W-1:0] x_start,
    output logic [DATA_W-1:0] y_start,
    output logic [DATA_W-1:0] step,
    output logic [ITER_W-1:0] max_iter,
    output logic              run,
    output logic              start,
    output logic              cfg_wr,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_W = ADDR_W + DATA_W;
`ifdef DD_SPI_PARITY_EN
    localparam int LEN = FRAME_W + 1;
`else
    localparam int LEN = FRAME_W;
`endif
    localparam int CNT_W = $clog2(LEN + 2);
    localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [2:0]        sclkPipe_q;
    logic [2:0]        enPipe_q;
    logic [1:0]        dataPipe_q;
    logic              sclkRise_q;
    logic              enRise_q;
    logic              enFall_q;
    logic              bit_q;
    logic [1:0]        settle_q;
    logic              armed_q;

    state_t            state_q;
    logic [LEN-1:0]    shift_q;
    logic [LEN-1:0]    shift_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] xStart_q;
    logic [DATA_W-1:0] yStart_q;
    logic [DATA_W-1:0] step_q;
    logic [ITER_W-1:0] maxIter_q;
    logic              run_q;
    logic              start_q;
    logic              cfgWr_q;
    logic              frameErr_q;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] payload;
    logic              parityOk;
    logic              frameOk;

    // Edge flags are registered so the clock-edge and enable-edge of one frame line up in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclkPipe_q <= '0;
            enPipe_q   <= '0;
            dataPipe_q <= '0;
            sclkRise_q <= 1'b0;
            enRise_q   <= 1'b0;
            enFall_q   <= 1'b0;
            bit_q      <= 1'b0;
            settle_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            sclkPipe_q <= {sclkPipe_q[1:0], spi_clk};
            enPipe_q   <= {enPipe_q[1:0], spi_en};
            dataPipe_q <= {dataPipe_q[0], spi_data};
            sclkRise_q <= sclkPipe_q[1] & ~sclkPipe_q[2];
            enRise_q   <= enPipe_q[1] & ~enPipe_q[2];
            enFall_q   <= ~enPipe_q[1] & enPipe_q[2];
            bit_q      <= dataPipe_q[1];
            if (settle_q != 2'd3)
                settle_q <= settle_q + 2'd1;
            armed_q    <= armed_q | ((settle_q == 2'd3) & ~enPipe_q[1]);
        end
    end

    always_comb begin
        shift_d = {shift_q[LEN-2:0], bit_q};
        count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        addr    = shift_q[LEN-1 -: ADDR_W];
        payload = shift_q[LEN-1-ADDR_W -: DATA_W];
`ifdef DD_SPI_PARITY_EN
        parityOk = ~^shift_q;
`else
        parityOk = 1'b1;
`endif
        frameOk = (count_q == CNT_LEN) && (addr <= ADDR_W'(4)) && parityOk;
    end

    // Registers and pulses update on the edge entering COMMIT, so they are visible during COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            xStart_q   <= '0;
            yStart_q   <= '0;
            step_q     <= '0;
            maxIter_q  <= '1;
            run_q      <= 1'b0;
            start_q    <= 1'b0;
            cfgWr_q    <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            start_q    <= 1'b0;
            cfgWr_q    <= 1'b0;
            frameErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (armed_q && enRise_q) begin
                        state_q <= SHIFT;
                        shift_q <= '0;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    if (enFall_q) begin
                        state_q <= COMMIT;
                        if (frameOk) begin
                            cfgWr_q <= 1'b1;
                            case (addr)
                                ADDR_W'(0): xStart_q  <= payload;
                                ADDR_W'(1): yStart_q  <= payload;
                                ADDR_W'(2): step_q    <= payload;
                                ADDR_W'(3): maxIter_q <= payload[ITER_W-1:0];
                                default: begin
                                    run_q   <= payload[0];
                                    start_q <= payload[0];
                                end
                            endcase
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end else if (sclkRise_q) begin
                        shift_q <= shift_d;
                        count_q <= count_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_start   = xStart_q;
    assign y_start   = yStart_q;
    assign step      = step_q;
    assign max_iter  = maxIter_q;
    assign run       = run_q;
    assign start     = start_q;
    assign cfg_wr    = cfgWr_q;
    assign frame_err = frameErr_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_dd_spi_cfg_rx.sv
// Self-checking bench for dd_spi_cfg_rx: directed SPI frames against a frame-level register model.
// Define DD_SPI_PARITY_EN to exercise the parity build.
module tb_dd_spi_cfg_rx;

    localparam int FRAME_W = 24;
`ifdef DD_SPI_PARITY_EN
    localparam int LEN = FRAME_W + 1;
`else
    localparam int LEN = FRAME_W;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        spi_en;
    logic        spi_data;
    logic [15:0] x_start;
    logic [15:0] y_start;
    logic [15:0] step;
    logic [7:0]  max_iter;
    logic        run;
    logic        start;
    logic        cfg_wr;
    logic        frame_err;
    logic        busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCnt    = 0;

    // Frame-level model: expected register values and a pending commit scheduled 4 clocks after spi_en falls.
    logic [15:0] xExp, yExp, stepExp;
    logic [7:0]  iterExp;
    logic        runExp, startExp, cfgExp, errExp;
    logic [31:0] pendBits;
    int          pendN;
    int          commitAt;
    bit          pendValid = 1'b0;

    dd_spi_cfg_rx dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en), .spi_data(spi_data),
        .x_start(x_start), .y_start(y_start), .step(step), .max_iter(max_iter),
        .run(run), .start(start), .cfg_wr(cfg_wr), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycleCnt, actual, expected);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Decode a finished frame from its raw bit list and apply it to the expected state.
    task automatic modelCommit(input logic [31:0] bits, input int nbits);
        logic [31:0] frame;
        int          addr;
        bit          ok;
`ifdef DD_SPI_PARITY_EN
        frame = bits >> 1;
        ok    = (nbits == LEN) && ($countones(bits) % 2 == 0);
`else
        frame = bits;
        ok    = (nbits == LEN);
`endif
        addr = int'((frame >> 16) & 32'hFF);
        ok   = ok && (addr <= 4);
        if (ok) begin
            cfgExp = 1'b1;
            case (addr)
                0: xExp    = frame[15:0];
                1: yExp    = frame[15:0];
                2: stepExp = frame[15:0];
                3: iterExp = frame[7:0];
                default: begin
                    runExp   = frame[0];
                    startExp = frame[0];
                end
            endcase
        end else begin
            errExp = 1'b1;
        end
    endtask

    // Every cycle out of reset, all registered outputs must match the model.
    always @(negedge clk) begin
        if (rst) begin
            xExp = '0; yExp = '0; stepExp = '0; iterExp = 8'hFF; runExp = 1'b0;
            pendValid = 1'b0;
        end else begin
            startExp = 1'b0; cfgExp = 1'b0; errExp = 1'b0;
            if (pendValid && cycleCnt == commitAt) begin
                pendValid = 1'b0;
                modelCommit(pendBits, pendN);
            end
            checkOutput("x_start", 32'(x_start), 32'(xExp));
            checkOutput("y_start", 32'(y_start), 32'(yExp));
            checkOutput("step", 32'(step), 32'(stepExp));
            checkOutput("max_iter", 32'(max_iter), 32'(iterExp));
            checkOutput("run", 32'(run), 32'(runExp));
            checkOutput("start", 32'(start), 32'(startExp));
            checkOutput("cfg_wr", 32'(cfg_wr), 32'(cfgExp));
            checkOutput("frame_err", 32'(frame_err), 32'(errExp));
        end
    end

    // Shift nbits of bits MSB first at spi_clk = clk/8; optionally pulse rst before bit index rstAfter.
    task automatic applyStimulus(input logic [31:0] bits, input int nbits, input bit armedExp, input int rstAfter);
        spi_en = 1'b1;
        ticks(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            if ((nbits - 1 - i) == rstAfter) begin
                rst = 1'b1;
                ticks(2);
                rst = 1'b0;
                ticks(2);
            end
            spi_data = bits[i];
            ticks(4);
            if (i == 1) checkOutput("busy_mid", 32'(busy), 32'(armedExp));
            spi_clk = 1'b1;
            ticks(4);
            spi_clk = 1'b0;
        end
        ticks(4);
        spi_en = 1'b0;
        if (armedExp) begin
            pendBits  = bits;
            pendN     = nbits;
            commitAt  = cycleCnt + 4;
            pendValid = 1'b1;
        end
        ticks(8);
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic sendFrame(input logic [23:0] f);
`ifdef DD_SPI_PARITY_EN
        applyStimulus({7'h0, f, ^f}, LEN, 1'b1, -1);
`else
        applyStimulus({8'h0, f}, LEN, 1'b1, -1);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; spi_clk = 1'b0; spi_en = 1'b0; spi_data = 1'b0;
        ticks(3);
        rst = 1'b0;
        ticks(1);
        checkOutput("rst_x_start", 32'(x_start), 32'h0);
        checkOutput("rst_max_iter", 32'(max_iter), 32'hFF);
        checkOutput("rst_run", 32'(run), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        ticks(6);

        sendFrame(24'h00_C000);
        checkOutput("lit_x_start", 32'(x_start), 32'hC000);

        sendFrame(24'h04_0001);
        checkOutput("lit_run_on", 32'(run), 32'h1);
        sendFrame(24'h04_0000);
        checkOutput("lit_run_off", 32'(run), 32'h0);

        sendFrame(24'h02_0100);
        sendFrame(24'h01_8001);

        applyStimulus(32'h002A_AAAA, LEN - 1, 1'b1, -1);
        applyStimulus(32'h0123_4567, LEN + 1, 1'b1, -1);
        sendFrame(24'h07_5555);
        checkOutput("lit_x_keep", 32'(x_start), 32'hC000);
        checkOutput("lit_step_keep", 32'(step), 32'h0100);

        applyStimulus(32'h0000_BEEF, LEN, 1'b0, 10);
        ticks(4);
        checkOutput("lit_rst_x", 32'(x_start), 32'h0);
        sendFrame(24'h03_0040);
        checkOutput("lit_max_iter", 32'(max_iter), 32'h40);

`ifdef DD_SPI_PARITY_EN
        applyStimulus({7'h0, 24'h01_0001, 1'b0}, LEN, 1'b1, -1);
        checkOutput("lit_par_ok", 32'(y_start), 32'h1);
        applyStimulus({7'h0, 24'h01_0001, 1'b1}, LEN, 1'b1, -1);
        checkOutput("lit_par_bad", 32'(y_start), 32'h1);
`endif

        ticks(4);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
